// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if
//   Groups the byte stream handshake, the IMEM write port and the CPU status
//   lines that the boot loader drives.
//   Parameter: ADDR_W - IMEM word-address width.
//   Signals:
//     rx_data, rx_valid, rx_ready     byte stream, transfer on rx_valid & rx_ready
//     imem_we, imem_addr, imem_wdata  one-cycle IMEM word write
//     cpu_reset, done, error          CPU reset control and load status
//   Modports:
//     master - stream source / observer (drives rx_data, rx_valid)
//     slave  - the boot loader
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a length-prefixed little-endian word stream into instruction memory,
//   then releases the CPU from reset after a fixed hold time.
//   Stream: N[7:0], N[15:8], then N words of 4 bytes, LSB first.
//   Parameters:
//     ADDR_W      IMEM word-address width (capacity 2**ADDR_W words)
//     RESET_HOLD  cycles spent in HOLD before the CPU is released (>= 1)
//   Ports:
//     clk_i    clock, rising edge
//     reset_i  synchronous active-high reset
//     bus      imem_boot_loader_if.slave (stream in, IMEM write, CPU status)
//   Build option:
//     IMEM_LOAD_CHECKSUM_EN - adds a trailing XOR checksum byte checked in CHK.
//
// state  | meaning
// LEN_LO | waiting for length low byte
// LEN_HI | waiting for length high byte, length range check
// DATA   | assembling and writing data words
// CHK    | waiting for checksum byte (checksum build only)
// HOLD   | load complete, CPU still held in reset for RESET_HOLD cycles
// RUN    | CPU released, terminal until reset
// ERROR  | load failed, CPU held in reset, terminal until reset
module imem_boot_loader #(
    parameter int ADDR_W     = 8,
    parameter int RESET_HOLD = 4
) (
    input logic               clk_i,
    input logic               reset_i,
    imem_boot_loader_if.slave bus
);

    localparam logic [16:0]       CAPACITY  = 17'(1 << ADDR_W);
    localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CHK,
`endif
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        len_lo, len_lo_nxt;
    logic [16:0]       words_left, words_left_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [23:0]       word_buf, word_buf_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              imem_we, imem_we_nxt;
    logic [ADDR_W-1:0] imem_addr, imem_addr_nxt;
    logic [31:0]       imem_wdata, imem_wdata_nxt;
    logic              cpu_reset, cpu_reset_nxt;
    logic              done, done_nxt;
    logic              error, error_nxt;
    logic              ready_dec;
    logic              accept;
    logic [15:0]       len_full;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]        csum, csum_nxt;
`endif

    // Ready is a pure state decode, gated off while reset is applied.
    assign bus.rx_ready   = ready_dec & ~reset_i;
    assign accept         = bus.rx_valid & bus.rx_ready;
    assign len_full       = {bus.rx_data, len_lo};

    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_wdata = imem_wdata;
    assign bus.cpu_reset  = cpu_reset;
    assign bus.done       = done;
    assign bus.error      = error;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= S_LEN_LO;
            len_lo     <= '0;
            words_left <= '0;
            addr       <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            len_lo     <= len_lo_nxt;
            words_left <= words_left_nxt;
            addr       <= addr_nxt;
            byte_cnt   <= byte_cnt_nxt;
            word_buf   <= word_buf_nxt;
            hold_cnt   <= hold_cnt_nxt;
            imem_we    <= imem_we_nxt;
            imem_addr  <= imem_addr_nxt;
            imem_wdata <= imem_wdata_nxt;
            cpu_reset  <= cpu_reset_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum       <= csum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        len_lo_nxt     = len_lo;
        words_left_nxt = words_left;
        addr_nxt       = addr;
        byte_cnt_nxt   = byte_cnt;
        word_buf_nxt   = word_buf;
        hold_cnt_nxt   = hold_cnt;
        imem_we_nxt    = 1'b0;
        imem_addr_nxt  = imem_addr;
        imem_wdata_nxt = imem_wdata;
        cpu_reset_nxt  = cpu_reset;
        done_nxt       = done;
        error_nxt      = error;
        ready_dec      = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_nxt       = csum;
`endif

        case (state)
            S_LEN_LO: begin
                ready_dec = 1'b1;
                if (accept) begin
                    len_lo_nxt = bus.rx_data;
                    state_nxt  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                ready_dec = 1'b1;
                if (accept) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_HOLD;
`endif
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        state_nxt = S_ERROR;
                        error_nxt = 1'b1;
                    end else begin
                        words_left_nxt = {1'b0, len_full};
                        state_nxt      = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ready_dec = 1'b1;
                if (accept) begin
                    byte_cnt_nxt = byte_cnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_nxt = csum ^ bus.rx_data;
`endif
                    case (byte_cnt)
                        2'd0: word_buf_nxt[7:0]   = bus.rx_data;
                        2'd1: word_buf_nxt[15:8]  = bus.rx_data;
                        2'd2: word_buf_nxt[23:16] = bus.rx_data;
                        default: begin
                            imem_we_nxt    = 1'b1;
                            imem_addr_nxt  = addr;
                            imem_wdata_nxt = {bus.rx_data, word_buf};
                            addr_nxt       = addr + ADDR_W'(1);
                            words_left_nxt = words_left - 17'd1;
                            if (words_left == 17'd1) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                                state_nxt = S_CHK;
`else
                                state_nxt = S_HOLD;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CHK: begin
                ready_dec = 1'b1;
                if (accept) begin
                    if (bus.rx_data == csum) begin
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_ERROR;
                        error_nxt = 1'b1;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt     = S_RUN;
                    cpu_reset_nxt = 1'b0;
                    done_nxt      = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            S_RUN: begin
            end
            S_ERROR: begin
                cpu_reset_nxt = 1'b1;
                done_nxt      = 1'b0;
            end
            default: begin
                state_nxt = S_LEN_LO;
            end
        endcase

        // Arm the hold timer on every entry into HOLD so each path gets the full count.
        if (state_nxt == S_HOLD && state != S_HOLD) begin
            hold_cnt_nxt = HOLD_LOAD;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int ADDR_W     = 8;
    localparam int RESET_HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .ADDR_W     (ADDR_W),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_acc = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    // Observe writes and accepted bytes away from the active edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) n_acc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(bus.rx_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_we",     32'(bus.imem_we),   32'd0);
        check("rst_addr",   32'(bus.imem_addr), 32'd0);
        check("rst_wdata",  bus.imem_wdata,     32'd0);
        check("rst_cpurst", 32'(bus.cpu_reset), 32'd1);
        check("rst_done",   32'(bus.done),      32'd0);
        check("rst_error",  32'(bus.error),     32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(bus.rx_ready), 32'd1);
        wr_addr.delete();
        wr_data.delete();
        n_acc = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_gapped(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        send_byte(b);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (bus.done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    // Checks the cycle-exact release sequence; call right after the last byte's edge.
    task automatic check_release(input string tag);
        check({tag, "_we_pulse_or_hold"}, 32'(bus.cpu_reset), 32'd1);
        check({tag, "_ready_hold"}, 32'(bus.rx_ready), 32'd0);
        for (int i = 0; i < RESET_HOLD - 1; i++) begin
            @(posedge clk); #1;
            check({tag, "_cpurst_hold"}, 32'(bus.cpu_reset), 32'd1);
            check({tag, "_done_hold"},   32'(bus.done),      32'd0);
        end
        @(posedge clk); #1;
        check({tag, "_cpurst_run"}, 32'(bus.cpu_reset), 32'd0);
        check({tag, "_done_run"},   32'(bus.done),      32'd1);
        check({tag, "_error_run"},  32'(bus.error),     32'd0);
    endtask

    logic [7:0] s1 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h0F, 8'h10, 8'h00};
    logic [7:0] s5a [4] = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    logic [7:0] s5b [6] = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    int bad;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // 1: two-word program, exact write timing and release timing
        do_reset();
        foreach (s1[i]) send_byte(s1[i]);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(8'h9F);
`endif
        check("t1_ready_after_load", 32'(bus.rx_ready), 32'd0);
        check_release("t1");
        check("t1_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t1_addr0", 32'(wr_addr[0]), 32'd0);
            check("t1_data0", wr_data[0], 32'h0000_0013);
            check("t1_addr1", 32'(wr_addr[1]), 32'd1);
            check("t1_data1", wr_data[1], 32'h0010_0F93);
        end
        check("t1_addr_held",  32'(bus.imem_addr), 32'd1);
        check("t1_wdata_held", bus.imem_wdata, 32'h0010_0F93);
        check("t1_we_low",     32'(bus.imem_we), 32'd0);

        // 2: empty program
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check_release("t2");
        check("t2_nwr", 32'(wr_addr.size()), 32'd0);

        // 3: length overflow by one word
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        check("t3_error",  32'(bus.error),     32'd1);
        check("t3_ready",  32'(bus.rx_ready),  32'd0);
        check("t3_cpurst", 32'(bus.cpu_reset), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("t3_error_sticky",  32'(bus.error),     32'd1);
        check("t3_cpurst_sticky", 32'(bus.cpu_reset), 32'd1);
        check("t3_done",          32'(bus.done),      32'd0);
        check("t3_nwr",           32'(wr_addr.size()), 32'd0);

        // 4: same program with bubbles, extra bytes offered through HOLD and RUN
        do_reset();
        foreach (s1[i]) send_gapped(s1[i]);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_gapped(8'h9F);
`endif
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rx_ready !== 1'b0) bad++;
        end
        bus.rx_valid = 1'b0;
        check("t4_ready_low_cycles", 32'(bad), 32'd0);
        check("t4_done", 32'(bus.done), 32'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("t4_accepts", 32'(n_acc), 32'd11);
`else
        check("t4_accepts", 32'(n_acc), 32'd10);
`endif
        check("t4_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t4_data0", wr_data[0], 32'h0000_0013);
            check("t4_data1", wr_data[1], 32'h0010_0F93);
            check("t4_addr1", 32'(wr_addr[1]), 32'd1);
        end

        // 5: reset in the middle of a word discards it
        do_reset();
        foreach (s5a[i]) send_byte(s5a[i]);
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_partial_wr", 32'(wr_addr.size()), 32'd0);
        do_reset();
        foreach (s5b[i]) send_byte(s5b[i]);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(8'h44);
`endif
        wait_done("t5_done");
        check("t5_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t5_addr0", 32'(wr_addr[0]), 32'd0);
            check("t5_data0", wr_data[0], 32'h4433_2211);
        end

        // Full capacity: N = 2**ADDR_W, word i = {C3, 5A, ~i, i}
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(~8'(i));
            send_byte(8'h5A);
            send_byte(8'hC3);
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done("tf_done");
        check("tf_error", 32'(bus.error), 32'd0);
        check("tf_nwr", 32'(wr_addr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 8'(i)) bad++;
            if (wr_data[i] !== {8'hC3, 8'h5A, ~8'(i), 8'(i)}) bad++;
        end
        check("tf_bad_entries", 32'(bad), 32'd0);
        if (wr_addr.size() == 256) begin
            check("tf_last_addr", 32'(wr_addr[255]), 32'd255);
            check("tf_last_data", wr_data[255], 32'hC35A_00FF);
        end
        check("tf_addr_held", 32'(bus.imem_addr), 32'd255);

`ifdef IMEM_LOAD_CHECKSUM_EN
        // 6: bad checksum
        do_reset();
        foreach (s1[i]) send_byte(s1[i]);
        send_byte(8'h00);
        check("t6_error",  32'(bus.error),     32'd1);
        check("t6_cpurst", 32'(bus.cpu_reset), 32'd1);
        check("t6_ready",  32'(bus.rx_ready),  32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("t6_done", 32'(bus.done), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
